// File: rtl/dualport_ram_be.sv
// Dual-port synchronous RAM with byte-lane write enables.
// Two masters share one array on a single clock. After reset, a sequencer
// zero-fills the whole array before any access is accepted.
// Same-address writes are merged lane by lane, and the merge is flagged.
// Read data leaves through one register stage, or two when OUT_REG is set.
module dualport_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int WR_PRIO    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    en_a,
  input  logic                    en_b,
  input  logic [DATA_WIDTH/8-1:0] we_a,
  input  logic [DATA_WIDTH/8-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   wdata_a,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  output logic [DATA_WIDTH-1:0]   rdata_b,
  output logic                    rvalid_a,
  output logic                    rvalid_b,
  output logic                    collision,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic                    clr_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc_a;
  logic                    acc_b;
  logic                    inr_a;
  logic                    inr_b;
  logic                    wr_a;
  logic                    wr_b;
  logic                    coll;
  logic [NB-1:0]           lane_a;
  logic [NB-1:0]           lane_b;
  logic [DATA_WIDTH-1:0]   rd_a;
  logic [DATA_WIDTH-1:0]   rd_b;

  logic                    vld_a_p0;
  logic                    vld_b_p0;
  logic [DATA_WIDTH-1:0]   rdata_a_p0;
  logic [DATA_WIDTH-1:0]   rdata_b_p0;
  logic                    coll_p0;

  // Selects the byte returned for one lane: own write data when write-first
  // applies to that lane, otherwise the stored byte.
  function automatic logic [7:0] rdw_byte(input logic own_we,
                                          input logic [7:0] old_byte,
                                          input logic [7:0] new_byte);
    logic [7:0] b;
    b = old_byte;
    if ((RDW_MODE != 0) && own_we) b = new_byte;
    return b;
  endfunction

  // Sequencer state register: reset always restarts the zero-fill.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Sequencer next state: leave CLEAR on the edge that zeroes the last word.
  always_comb begin
    state_d = state_q;
    if ((state_q == CLEAR) && (clr_ptr == LAST_ADDR)) state_d = RUN;
  end

  // Sequencer outputs: busy for the whole fill, clear strobe only out of reset.
  always_comb begin
    busy   = (state_q == CLEAR);
    clr_we = (state_q == CLEAR) && rst_n;
  end

  // Clear pointer walks the array once per fill.
  always_ff @(posedge clk) begin
    if (!rst_n)      clr_ptr <= '0;
    else if (clr_we) clr_ptr <= clr_ptr + 1'b1;
  end

  // Access qualification, collision detect and per-lane write arbitration.
  always_comb begin
    acc_a  = (state_q == RUN) && rst_n && ce && en_a;
    acc_b  = (state_q == RUN) && rst_n && ce && en_b;
    inr_a  = ({1'b0, addr_a} < DEPTH_L);
    inr_b  = ({1'b0, addr_b} < DEPTH_L);
    wr_a   = acc_a && inr_a && (|we_a);
    wr_b   = acc_b && inr_b && (|we_b);
    coll   = wr_a && wr_b && (addr_a == addr_b);
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < NB; i++) begin
      lane_a[i] = acc_a && inr_a && we_a[i] &&
                  !(coll && we_b[i] && (WR_PRIO != 0));
      lane_b[i] = acc_b && inr_b && we_b[i] &&
                  !(coll && we_a[i] && (WR_PRIO == 0));
    end
  end

  // Read word per port; the other port's same-cycle write is never forwarded.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (inr_a) begin
      for (int i = 0; i < NB; i++)
        rd_a[8*i +: 8] = rdw_byte(we_a[i], mem[addr_a][8*i +: 8], wdata_a[8*i +: 8]);
    end
    if (inr_b) begin
      for (int i = 0; i < NB; i++)
        rd_b[8*i +: 8] = rdw_byte(we_b[i], mem[addr_b][8*i +: 8], wdata_b[8*i +: 8]);
    end
  end

  // Storage array: zero-fill while clearing, arbitrated lane writes in RUN.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_ptr] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (lane_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      if (lane_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
  end

  // ---- stage p0: read result register ----
  // Capture read results; data only moves when its access is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_a_p0   <= 1'b0;
      vld_b_p0   <= 1'b0;
      coll_p0    <= 1'b0;
      rdata_a_p0 <= '0;
      rdata_b_p0 <= '0;
    end else if (ce) begin
      vld_a_p0 <= acc_a;
      vld_b_p0 <= acc_b;
      coll_p0  <= coll;
      if (acc_a) rdata_a_p0 <= rd_a;
      if (acc_b) rdata_b_p0 <= rd_b;
    end
  end

  // ---- stage p1: optional output register ----
  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld_a_p1;
    logic                  vld_b_p1;
    logic                  coll_p1;
    logic [DATA_WIDTH-1:0] rdata_a_p1;
    logic [DATA_WIDTH-1:0] rdata_b_p1;

    // Second output stage; freezes with ce like the first.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_a_p1   <= 1'b0;
        vld_b_p1   <= 1'b0;
        coll_p1    <= 1'b0;
        rdata_a_p1 <= '0;
        rdata_b_p1 <= '0;
      end else if (ce) begin
        vld_a_p1 <= vld_a_p0;
        vld_b_p1 <= vld_b_p0;
        coll_p1  <= coll_p0;
        if (vld_a_p0) rdata_a_p1 <= rdata_a_p0;
        if (vld_b_p0) rdata_b_p1 <= rdata_b_p0;
      end
    end

    assign rdata_a   = rdata_a_p1;
    assign rdata_b   = rdata_b_p1;
    assign rvalid_a  = vld_a_p1;
    assign rvalid_b  = vld_b_p1;
    assign collision = coll_p1;
  end else begin : g_no_out_reg
    assign rdata_a   = rdata_a_p0;
    assign rdata_b   = rdata_b_p0;
    assign rvalid_a  = vld_a_p0;
    assign rvalid_b  = vld_b_p0;
    assign collision = coll_p0;
  end

endmodule

// File: tb/tb_dualport_ram_be.sv
// Bench for dualport_ram_be. Two instances share the access inputs but have
// their own clock enable and reset. u0 uses the default parameters and is
// driven from a vector table. u1 (DEPTH=12, write-first, output register,
// port B priority) is driven by hand-written sequences.
module tb_dualport_ram_be;

  logic        clk;
  logic        rst_n0, rst_n1;
  logic        ce0, ce1;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;

  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
  logic        collision0, collision1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  dualport_ram_be u0 (
    .clk(clk), .rst_n(rst_n0), .ce(ce0), .en_a(en_a), .en_b(en_b),
    .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0),
    .rvalid_a(rvalid_a0), .rvalid_b(rvalid_b0),
    .collision(collision0), .busy(busy0)
  );

  dualport_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12),
    .RDW_MODE(1), .OUT_REG(1), .WR_PRIO(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n1), .ce(ce1), .en_a(en_a), .en_b(en_b),
    .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .rdata_a(rdata_a1), .rdata_b(rdata_b1),
    .rvalid_a(rvalid_a1), .rvalid_b(rvalid_b1),
    .collision(collision1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ce;
    logic        en_a;
    logic [3:0]  we_a;
    logic [3:0]  ad_a;
    logic [31:0] wd_a;
    logic        en_b;
    logic [3:0]  we_b;
    logic [3:0]  ad_b;
    logic [31:0] wd_b;
    logic        va;
    logic [31:0] ra;
    logic        vb;
    logic [31:0] rb;
    logic        co;
  } vec_t;

  vec_t vecs[15];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic [3:0] we, input logic [3:0] ad,
                       input logic [31:0] wd);
    en_a = en; we_a = we; addr_a = ad; wdata_a = wd;
  endtask

  task automatic set_b(input logic en, input logic [3:0] we, input logic [3:0] ad,
                       input logic [31:0] wd);
    en_b = en; we_b = we; addr_b = ad; wdata_b = wd;
  endtask

  task automatic idle();
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
  endtask

  initial begin
    int  n0, n1, n;
    logic rv_busy0, rv_busy1;

    //                ce    en_a we_a  ad_a   wd_a           en_b  we_b  ad_b   wd_b           va    ra             vb    rb             co
    vecs[0]  = '{1'b1, 1'b1,4'h0,4'd0,32'h00000000, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,32'h00000000, 1'b0,32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1,4'hF,4'd3,32'hAABBCCDD, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,32'h00000000, 1'b0,32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,4'h5,4'd3,32'h11223344, 1'b0,32'h00000000, 1'b1,32'hAABBCCDD, 1'b0};
    vecs[3]  = '{1'b1, 1'b1,4'h0,4'd3,32'h00000000, 1'b1,4'h0,4'd3,32'h00000000, 1'b1,32'hAA22CC44, 1'b1,32'hAA22CC44, 1'b0};
    vecs[4]  = '{1'b1, 1'b1,4'hF,4'd5,32'h12345678, 1'b1,4'h0,4'd5,32'h00000000, 1'b1,32'h00000000, 1'b1,32'h00000000, 1'b0};
    vecs[5]  = '{1'b1, 1'b1,4'h0,4'd5,32'h00000000, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,32'h12345678, 1'b0,32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1,4'h3,4'd7,32'hFFFFFFFF, 1'b1,4'h6,4'd7,32'h00000000, 1'b1,32'h00000000, 1'b1,32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1,4'hF,4'd7,32'h12345678, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,32'h00000000, 1'b1,32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 1'b1,4'h0,4'd7,32'h00000000, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,32'h0000FFFF, 1'b0,32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1,4'hF,4'd1,32'h01020304, 1'b1,4'hF,4'd2,32'h05060708, 1'b1,32'h00000000, 1'b1,32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 1'b1,4'h0,4'd2,32'h00000000, 1'b1,4'h0,4'd1,32'h00000000, 1'b1,32'h05060708, 1'b1,32'h01020304, 1'b0};
    vecs[11] = '{1'b1, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,4'h8,4'd3,32'hEEEEEEEE, 1'b0,32'h05060708, 1'b1,32'hAA22CC44, 1'b0};
    vecs[12] = '{1'b1, 1'b1,4'h0,4'd3,32'h00000000, 1'b1,4'h0,4'd3,32'h00000000, 1'b1,32'hEE22CC44, 1'b1,32'hEE22CC44, 1'b0};
    vecs[13] = '{1'b1, 1'b1,4'h0,4'd4,32'h00000000, 1'b1,4'hF,4'd4,32'hCAFEBABE, 1'b1,32'h00000000, 1'b1,32'h00000000, 1'b0};
    vecs[14] = '{1'b1, 1'b1,4'h0,4'd4,32'h00000000, 1'b0,4'h0,4'd0,32'h00000000, 1'b1,32'hCAFEBABE, 1'b0,32'h00000000, 1'b0};

    // Reset both instances with port A requesting every cycle.
    rst_n0 = 1'b0; rst_n1 = 1'b0; ce0 = 1'b1; ce1 = 1'b0;
    idle();
    set_a(1'b1, 4'h0, 4'd0, 32'h0);
    repeat (3) step();
    chk1("rst busy0", busy0, 1'b1);
    chk1("rst busy1", busy1, 1'b1);
    chk1("rst rvalid_a0", rvalid_a0, 1'b0);
    chk1("rst rvalid_b0", rvalid_b0, 1'b0);
    chk32("rst rdata_a0", rdata_a0, 32'h0);
    chk32("rst rdata_b0", rdata_b0, 32'h0);
    chk1("rst collision0", collision0, 1'b0);
    chk1("rst rvalid_a1", rvalid_a1, 1'b0);
    chk32("rst rdata_a1", rdata_a1, 32'h0);
    chk1("rst collision1", collision1, 1'b0);

    // Count edges until each busy falls.
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    n0 = 0; n1 = 0; rv_busy0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (busy0 && rvalid_a0) rv_busy0 = 1'b1;
      if (n0 == 0 && !busy0) begin
        n0 = k;
        if (rvalid_a0) rv_busy0 = 1'b1;
      end
      if (n1 == 0 && !busy1) n1 = k;
      if (n0 != 0 && n1 != 0) break;
    end
    idle();
    chkint("clear edges u0", n0, 16);
    chkint("clear edges u1", n1, 12);
    chk1("rvalid during clear u0", rv_busy0, 1'b0);

    // Every address of u0 reads zero after the fill.
    for (int a = 0; a < 16; a++) begin
      set_a(1'b1, 4'h0, a[3:0], 32'h0);
      step();
      chk1($sformatf("clr a%0d rvalid", a), rvalid_a0, 1'b1);
      chk32($sformatf("clr a%0d rdata", a), rdata_a0, 32'h0);
    end

    // Table-driven vectors on u0.
    for (int i = 0; i < 15; i++) begin
      ce0 = vecs[i].ce;
      set_a(vecs[i].en_a, vecs[i].we_a, vecs[i].ad_a, vecs[i].wd_a);
      set_b(vecs[i].en_b, vecs[i].we_b, vecs[i].ad_b, vecs[i].wd_b);
      step();
      chk1($sformatf("v%0d rvalid_a", i), rvalid_a0, vecs[i].va);
      chk32($sformatf("v%0d rdata_a", i), rdata_a0, vecs[i].ra);
      chk1($sformatf("v%0d rvalid_b", i), rvalid_b0, vecs[i].vb);
      chk32($sformatf("v%0d rdata_b", i), rdata_b0, vecs[i].rb);
      chk1($sformatf("v%0d collision", i), collision0, vecs[i].co);
    end
    idle();
    ce0 = 1'b0;
    ce1 = 1'b1;

    // u1: write-first on own port, old data on the other port, 2-cycle latency.
    set_a(1'b1, 4'hF, 4'd5, 32'h12345678);
    set_b(1'b1, 4'h0, 4'd5, 32'h0);
    step();
    idle();
    chk1("u1 rdw lat1 rvalid_a", rvalid_a1, 1'b0);
    step();
    chk1("u1 rdw rvalid_a", rvalid_a1, 1'b1);
    chk32("u1 rdw rdata_a new", rdata_a1, 32'h12345678);
    chk1("u1 rdw rvalid_b", rvalid_b1, 1'b1);
    chk32("u1 rdw rdata_b old", rdata_b1, 32'h0);
    step();
    chk1("u1 rdw rvalid_a drop", rvalid_a1, 1'b0);
    chk32("u1 rdw rdata_a hold", rdata_a1, 32'h12345678);

    // u1: collision with port B priority.
    set_a(1'b1, 4'h3, 4'd7, 32'hFFFFFFFF);
    set_b(1'b1, 4'h6, 4'd7, 32'h00000000);
    step();
    idle();
    chk1("u1 coll lat1", collision1, 1'b0);
    step();
    chk1("u1 coll pulse", collision1, 1'b1);
    step();
    chk1("u1 coll once", collision1, 1'b0);
    set_a(1'b1, 4'h0, 4'd7, 32'h0);
    step();
    idle();
    step();
    chk32("u1 coll merged", rdata_a1, 32'h000000FF);

    // u1: fill addrs 0..3, then stream reads with a 2-cycle ce drop.
    for (int a = 0; a < 4; a++) begin
      set_a(1'b1, 4'hF, a[3:0], 32'hA0A00000 | a);
      step();
    end
    idle();
    step();
    step();
    chk1("u1 stream pre rvalid", rvalid_a1, 1'b0);
    set_a(1'b1, 4'h0, 4'd0, 32'h0);
    step();
    chk1("u1 stream E1 rvalid", rvalid_a1, 1'b0);
    set_a(1'b1, 4'h0, 4'd1, 32'h0);
    step();
    chk1("u1 stream E2 rvalid", rvalid_a1, 1'b1);
    chk32("u1 stream E2 rdata", rdata_a1, 32'hA0A00000);
    ce1 = 1'b0;
    set_a(1'b1, 4'h0, 4'd2, 32'h0);
    step();
    chk1("u1 stream E3 rvalid", rvalid_a1, 1'b1);
    chk32("u1 stream E3 rdata", rdata_a1, 32'hA0A00000);
    step();
    chk1("u1 stream E4 rvalid", rvalid_a1, 1'b1);
    chk32("u1 stream E4 rdata", rdata_a1, 32'hA0A00000);
    ce1 = 1'b1;
    step();
    chk32("u1 stream E5 rdata", rdata_a1, 32'hA0A00001);
    set_a(1'b1, 4'h0, 4'd3, 32'h0);
    step();
    chk32("u1 stream E6 rdata", rdata_a1, 32'hA0A00002);
    idle();
    step();
    chk1("u1 stream E7 rvalid", rvalid_a1, 1'b1);
    chk32("u1 stream E7 rdata", rdata_a1, 32'hA0A00003);
    step();
    chk1("u1 stream E8 rvalid", rvalid_a1, 1'b0);
    chk32("u1 stream E8 rdata", rdata_a1, 32'hA0A00003);

    // u1: out-of-range write then read of addr 13 (DEPTH=12).
    set_a(1'b1, 4'hF, 4'd13, 32'hDEADBEEF);
    step();
    set_a(1'b1, 4'h0, 4'd13, 32'h0);
    step();
    idle();
    chk1("u1 oor wr rvalid", rvalid_a1, 1'b1);
    chk32("u1 oor wr rdata", rdata_a1, 32'h0);
    step();
    chk1("u1 oor rd rvalid", rvalid_a1, 1'b1);
    chk32("u1 oor rd rdata", rdata_a1, 32'h0);
    step();
    chk1("u1 oor done rvalid", rvalid_a1, 1'b0);

    // u1: one-edge reset mid-run restarts the fill and wipes contents.
    set_a(1'b1, 4'h0, 4'd0, 32'h0);
    rst_n1 = 1'b0;
    step();
    chk1("u1 rerst busy", busy1, 1'b1);
    chk1("u1 rerst rvalid_a", rvalid_a1, 1'b0);
    chk32("u1 rerst rdata_a", rdata_a1, 32'h0);
    rst_n1 = 1'b1;
    n = 0; rv_busy1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rvalid_a1) rv_busy1 = 1'b1;
      if (!busy1) begin
        n = k;
        break;
      end
    end
    chkint("u1 refill edges", n, 12);
    chk1("u1 rvalid during refill", rv_busy1, 1'b0);
    set_a(1'b1, 4'h0, 4'd5, 32'h0);
    set_b(1'b1, 4'h0, 4'd0, 32'h0);
    step();
    idle();
    step();
    chk1("u1 after refill rvalid_a", rvalid_a1, 1'b1);
    chk32("u1 after refill addr5", rdata_a1, 32'h0);
    chk1("u1 after refill rvalid_b", rvalid_b1, 1'b1);
    chk32("u1 after refill addr0", rdata_b1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
